// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts neuron spikes over a programmable window of update steps
// and presents the count through a valid/ready result register.
// Optional macro FIRST_SPIKE_LATENCY_EN adds the first_spike_step output.
module spike_rate_decoder #(
    parameter int COUNT_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spike_valid,
    input  logic                    spike,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    continuous,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic                    out_ready,
    output logic                    rate_valid,
    output logic [COUNT_WIDTH-1:0]  rate_count,
    output logic                    rate_sat,
    output logic                    overrun,
    output logic                    busy
`ifdef FIRST_SPIKE_LATENCY_EN
    ,
    output logic [WINDOW_WIDTH-1:0] first_spike_step
`endif
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [WINDOW_WIDTH-1:0] STEP_ONE = WINDOW_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE  = COUNT_WIDTH'(1);

    state_t                  state, state_next;
    logic [WINDOW_WIDTH-1:0] step_cnt, len_q;
    logic [COUNT_WIDTH-1:0]  spike_cnt, res_cnt;
    logic                    sat_q, res_sat;
    logic                    start_ok, step, hit, final_step, cnt_full, load;
`ifdef FIRST_SPIKE_LATENCY_EN
    logic [WINDOW_WIDTH-1:0] first_q, res_first;
`endif

    // abort suppresses the step entirely, so a same-cycle final step yields no result.
    always_comb begin
        start_ok   = (state == IDLE) && start && !abort && (window_len != '0);
        step       = (state == COUNT) && spike_valid && !abort;
        hit        = step && spike;
        final_step = step && (step_cnt == len_q - STEP_ONE);
        cnt_full   = &spike_cnt;
        res_cnt    = (hit && !cnt_full) ? spike_cnt + CNT_ONE : spike_cnt;
        res_sat    = sat_q | (hit & cnt_full);
        load       = final_step && (!rate_valid || out_ready);
`ifdef FIRST_SPIKE_LATENCY_EN
        res_first  = (hit && (first_q == '1)) ? step_cnt : first_q;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COUNT;
            COUNT:   if (abort || (final_step && !continuous)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A final step clears the counters in place, so a continuous window loses no step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt  <= '0;
            spike_cnt <= '0;
            len_q     <= '0;
            sat_q     <= 1'b0;
`ifdef FIRST_SPIKE_LATENCY_EN
            first_q   <= '1;
`endif
        end else if (start_ok || final_step) begin
            step_cnt  <= '0;
            spike_cnt <= '0;
            sat_q     <= 1'b0;
            if (start_ok) len_q <= window_len;
`ifdef FIRST_SPIKE_LATENCY_EN
            first_q   <= '1;
`endif
        end else if (step) begin
            step_cnt  <= step_cnt + STEP_ONE;
            spike_cnt <= res_cnt;
            sat_q     <= res_sat;
`ifdef FIRST_SPIKE_LATENCY_EN
            first_q   <= res_first;
`endif
        end
    end

    // Result register: a new result replaces the held one only if it is empty or being read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_valid       <= 1'b0;
            rate_count       <= '0;
            rate_sat         <= 1'b0;
            overrun          <= 1'b0;
`ifdef FIRST_SPIKE_LATENCY_EN
            first_spike_step <= '1;
`endif
        end else begin
            if (load) begin
                rate_valid       <= 1'b1;
                rate_count       <= res_cnt;
                rate_sat         <= res_sat;
`ifdef FIRST_SPIKE_LATENCY_EN
                first_spike_step <= res_first;
`endif
            end else if (rate_valid && out_ready) begin
                rate_valid <= 1'b0;
            end
            if (final_step && !load) overrun <= 1'b1;
        end
    end

    assign busy = (state == COUNT);

endmodule
